// File: rtl/regfile_2r1w_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_2r1w_param_if                                                       |
// | Access bundle for the 2R/1W register file: write port, shared-enable read   |
// | ports, ready and the debug write counter.                                   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface regfile_2r1w_param_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            ready;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] write_data;
  logic            w_en;
  logic [AW-1:0]   r1;
  logic [AW-1:0]   r2;
  logic            r_en;
  logic [XLEN-1:0] r1_read;
  logic [XLEN-1:0] r2_read;
  logic [15:0]     wr_count;

  modport master (
    input  ready, r1_read, r2_read, wr_count,
    output rd, write_data, w_en, r1, r2, r_en
  );

  modport slave (
    output ready, r1_read, r2_read, wr_count,
    input  rd, write_data, w_en, r1, r2, r_en
  );
endinterface
`default_nettype wire

// File: rtl/regfile_2r1w_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_2r1w_param                                                          |
// | Parametrised 2-read/1-write register file with post-reset clear sweep and   |
// | registered read ports. Optional macro REGFILE_BYPASS_EN enables same-edge   |
// | write-to-read forwarding.                                                   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module regfile_2r1w_param #(
  parameter int XLEN        = 32,
  parameter int AW          = 5,
  parameter bit ZERO_IDX_EN = 1'b1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  regfile_2r1w_param_if.slave   bus
);
  localparam int NREGS = 2**AW;
  localparam logic [AW:0] c_last_idx     = (AW+1)'(NREGS-1);
  localparam logic [15:0] c_wr_count_max = 16'hFFFF;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW:0]     r_clr_ptr;
  logic            r_ready;
  logic [XLEN-1:0] r_mem [NREGS];
  logic [XLEN-1:0] r_r1_read;
  logic [XLEN-1:0] r_r2_read;
  logic [15:0]     r_wr_count;

  logic            w_clear_wr;
  logic            w_wr_commit;
  logic            w_rd_is_zero;
  logic            w_r1_is_zero;
  logic            w_r2_is_zero;
  logic            w_r1_fwd;
  logic            w_r2_fwd;
  logic [XLEN-1:0] w_r1_data;
  logic [XLEN-1:0] w_r2_data;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_CLEAR;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear_wr  = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clear_wr = 1'b1;
        if (r_clr_ptr == c_last_idx) w_state_nxt = S_RUN;
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Extra MSB keeps the terminal count distinct from a wrapped index.
  always_ff @(posedge clk) begin
    if (!rst_n)          r_clr_ptr <= '0;
    else if (w_clear_wr) r_clr_ptr <= r_clr_ptr + 1'b1;
  end

  // Ready lags entry into RUN by one edge and also gates every access.
  always_ff @(posedge clk) begin
    if (!rst_n) r_ready <= 1'b0;
    else        r_ready <= (r_state == S_RUN);
  end

  generate
    if (ZERO_IDX_EN) begin : g_zero_idx
      assign w_rd_is_zero = (bus.rd == '0);
      assign w_r1_is_zero = (bus.r1 == '0);
      assign w_r2_is_zero = (bus.r2 == '0);
    end else begin : g_plain_idx
      assign w_rd_is_zero = 1'b0;
      assign w_r1_is_zero = 1'b0;
      assign w_r2_is_zero = 1'b0;
    end
  endgenerate

  assign w_wr_commit = r_ready && bus.w_en && !w_rd_is_zero;

  // The array has no reset; the sweep clears it once rst_n is released.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_clear_wr)       r_mem[r_clr_ptr[AW-1:0]] <= '0;
      else if (w_wr_commit) r_mem[bus.rd]            <= bus.write_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign w_r1_fwd = bus.w_en && (bus.rd == bus.r1);
  assign w_r2_fwd = bus.w_en && (bus.rd == bus.r2);
`else
  assign w_r1_fwd = 1'b0;
  assign w_r2_fwd = 1'b0;
`endif

  always_comb begin
    w_r1_data = r_mem[bus.r1];
    w_r2_data = r_mem[bus.r2];
    if (w_r1_fwd) w_r1_data = bus.write_data;
    if (w_r2_fwd) w_r2_data = bus.write_data;
    if (w_r1_is_zero) w_r1_data = '0;
    if (w_r2_is_zero) w_r2_data = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_r1_read <= '0;
      r_r2_read <= '0;
    end else if (r_ready && bus.r_en) begin
      r_r1_read <= w_r1_data;
      r_r2_read <= w_r2_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_wr_count <= '0;
    else if (w_wr_commit && (r_wr_count != c_wr_count_max))
      r_wr_count <= r_wr_count + 16'd1;
  end

  assign bus.ready    = r_ready;
  assign bus.r1_read  = r_r1_read;
  assign bus.r2_read  = r_r2_read;
  assign bus.wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_2r1w_param                                                       |
// | Self-checking bench: default, plain-index-0 and 64x8 instances.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_regfile_2r1w_param;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_2r1w_param_if #(.XLEN(32), .AW(5)) bus    ();
  regfile_2r1w_param_if #(.XLEN(32), .AW(5)) bus_nz ();
  regfile_2r1w_param_if #(.XLEN(64), .AW(3)) bus_w  ();

  regfile_2r1w_param #(.XLEN(32), .AW(5), .ZERO_IDX_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  regfile_2r1w_param #(.XLEN(32), .AW(5), .ZERO_IDX_EN(1'b0)) u_dut_nz (
    .clk(clk), .rst_n(rst_n), .bus(bus_nz));
  regfile_2r1w_param #(.XLEN(64), .AW(3), .ZERO_IDX_EN(1'b1)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bus_w));

  int checks = 0;
  int passed = 0;

  // Reference model of the default instance (32 x 32, index 0 hardwired).
  logic [31:0] m_mem [32];
  logic [31:0] m_r1, m_r2;
  int          m_cnt;
  int          m_sweep;
  bit          m_ready;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (bus.w_en && bus.rd == a) return bus.write_data;
`endif
    return m_mem[a];
  endfunction

  task automatic step();
    if (!rst_n) begin
      m_sweep = 0; m_ready = 1'b0; m_r1 = '0; m_r2 = '0; m_cnt = 0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      if (m_ready) begin
        if (bus.r_en) begin
          m_r1 = m_read(bus.r1);
          m_r2 = m_read(bus.r2);
        end
        if (bus.w_en && bus.rd != 5'd0) begin
          m_mem[bus.rd] = bus.write_data;
          if (m_cnt < 65535) m_cnt++;
        end
      end
      if (m_sweep < 33) m_sweep++;
      m_ready = (m_sweep >= 33);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.w_en = 0; bus.r_en = 0; bus.rd = '0; bus.r1 = '0; bus.r2 = '0; bus.write_data = '0;
    bus_nz.w_en = 0; bus_nz.r_en = 0; bus_nz.rd = '0; bus_nz.r1 = '0; bus_nz.r2 = '0;
    bus_nz.write_data = '0;
    bus_w.w_en = 0; bus_w.r_en = 0; bus_w.rd = '0; bus_w.r1 = '0; bus_w.r2 = '0;
    bus_w.write_data = '0;
  endtask

  task automatic test_reset();
    int c_main = 0;
    int c_w = 0;
    idle_all();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({bus.ready, bus.r1_read, bus.r2_read, bus.wr_count} !== {1'b0, 32'd0, 32'd0, 16'd0})
      $display("FAIL reset_outputs: got ready=%b r1=%h r2=%h cnt=%h, want all zero",
               bus.ready, bus.r1_read, bus.r2_read, bus.wr_count);
    else passed++;
    rst_n = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (c_main == 0 && bus.ready) c_main = i;
      if (c_w == 0 && bus_w.ready) c_w = i;
      if (c_main != 0 && c_w != 0) break;
    end
    checks++;
    if (c_main !== 33) $display("FAIL sweep_32: ready at edge %0d, want 33", c_main);
    else passed++;
    checks++;
    if (c_w !== 9) $display("FAIL sweep_8: ready at edge %0d, want 9", c_w);
    else passed++;
    bus.r_en = 1; bus.r1 = 5'd31; bus.r2 = 5'd17;
    step();
    bus.r_en = 0;
    checks++;
    if ({bus.r1_read, bus.r2_read, bus.wr_count} !== {32'd0, 32'd0, 16'd0})
      $display("FAIL cleared_read: got r1=%h r2=%h cnt=%h, want zeros",
               bus.r1_read, bus.r2_read, bus.wr_count);
    else passed++;
  endtask

  task automatic test_basic();
    bus.w_en = 1; bus.rd = 5'd5; bus.write_data = 32'hDEADBEEF;
    step();
    bus.w_en = 0; bus.r_en = 1; bus.r1 = 5'd5; bus.r2 = 5'd7;
    step();
    bus.r_en = 0;
    checks++;
    if ({bus.r1_read, bus.r2_read, bus.wr_count} !== {32'hDEADBEEF, 32'd0, 16'd1})
      $display("FAIL basic_rw: got r1=%h r2=%h cnt=%0d, want deadbeef 0 1",
               bus.r1_read, bus.r2_read, bus.wr_count);
    else passed++;
  endtask

  task automatic test_zero_reg();
    bus.w_en = 1; bus.rd = 5'd0; bus.write_data = 32'h12345678;
    bus_nz.w_en = 1; bus_nz.rd = 5'd0; bus_nz.write_data = 32'h12345678;
    step();
    bus.w_en = 0; bus.r_en = 1; bus.r1 = 5'd0; bus.r2 = 5'd0;
    bus_nz.w_en = 0; bus_nz.r_en = 1; bus_nz.r1 = 5'd0; bus_nz.r2 = 5'd5;
    step();
    bus.r_en = 0; bus_nz.r_en = 0;
    checks++;
    if ({bus.r1_read, bus.wr_count} !== {32'd0, 16'd1})
      $display("FAIL zero_hardwired: got r1=%h cnt=%0d, want 0 1", bus.r1_read, bus.wr_count);
    else passed++;
    checks++;
    if ({bus_nz.r1_read, bus_nz.r2_read, bus_nz.wr_count} !== {32'h12345678, 32'd0, 16'd1})
      $display("FAIL zero_plain: got r1=%h r2=%h cnt=%0d, want 12345678 0 1",
               bus_nz.r1_read, bus_nz.r2_read, bus_nz.wr_count);
    else passed++;
  endtask

  task automatic test_hazard();
    logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hA5A5A5A5;
`else
    exp_same = 32'h00000001;
`endif
    bus.w_en = 1; bus.rd = 5'd3; bus.write_data = 32'h1;
    step();
    bus.write_data = 32'hA5A5A5A5; bus.r_en = 1; bus.r1 = 5'd3; bus.r2 = 5'd3;
    step();
    checks++;
    if ({bus.r1_read, bus.r2_read} !== {exp_same, exp_same})
      $display("FAIL hazard_same_edge: got r1=%h r2=%h, want %h", bus.r1_read, bus.r2_read, exp_same);
    else passed++;
    bus.w_en = 0;
    step();
    bus.r_en = 0;
    checks++;
    if (bus.r1_read !== 32'hA5A5A5A5)
      $display("FAIL hazard_next: got %h, want a5a5a5a5", bus.r1_read);
    else passed++;
  endtask

  task automatic test_hold_and_mid_reset();
    int c_main = 0;
    bus.r_en = 1; bus.r1 = 5'd5;
    step();
    bus.r_en = 0; bus.r1 = 5'd9;
    step();
    step();
    checks++;
    if (bus.r1_read !== 32'hDEADBEEF)
      $display("FAIL read_hold: got %h, want deadbeef", bus.r1_read);
    else passed++;
    rst_n = 1'b0; bus.w_en = 1; bus.rd = 5'd4; bus.write_data = 32'hCAFEF00D;
    step();
    rst_n = 1'b1; bus.w_en = 0;
    checks++;
    if ({bus.ready, bus.r1_read, bus.wr_count} !== {1'b0, 32'd0, 16'd0})
      $display("FAIL run_reset: got ready=%b r1=%h cnt=%0d, want 0 0 0",
               bus.ready, bus.r1_read, bus.wr_count);
    else passed++;
    repeat (10) step();
    rst_n = 1'b0; bus.w_en = 1; bus.rd = 5'd6;
    step();
    rst_n = 1'b1; bus.w_en = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (bus.ready) begin c_main = i; break; end
    end
    checks++;
    if (c_main !== 33) $display("FAIL mid_sweep_reset: ready at edge %0d, want 33", c_main);
    else passed++;
    bus.r_en = 1; bus.r1 = 5'd4; bus.r2 = 5'd6;
    step();
    bus.r_en = 0;
    checks++;
    if ({bus.r1_read, bus.r2_read, bus.wr_count} !== {32'd0, 32'd0, 16'd0})
      $display("FAIL reset_write_dropped: got r1=%h r2=%h cnt=%0d, want zeros",
               bus.r1_read, bus.r2_read, bus.wr_count);
    else passed++;
  endtask

  task automatic test_wide();
    bus_w.w_en = 1; bus_w.rd = 3'd7; bus_w.write_data = 64'hFFFF_0000_FFFF_0001;
    step();
    bus_w.w_en = 0; bus_w.r_en = 1; bus_w.r1 = 3'd7; bus_w.r2 = 3'd7;
    step();
    bus_w.r_en = 0;
    checks++;
    if ({bus_w.r1_read, bus_w.r2_read, bus_w.wr_count} !==
        {64'hFFFF_0000_FFFF_0001, 64'hFFFF_0000_FFFF_0001, 16'd1})
      $display("FAIL wide_rw: got r1=%h r2=%h cnt=%0d, want ffff0000ffff0001 x2, 1",
               bus_w.r1_read, bus_w.r2_read, bus_w.wr_count);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 700; i++) begin
      rst_n           = ($urandom_range(0, 199) != 0);
      bus.w_en        = 1'($urandom_range(0, 1));
      bus.rd          = 5'($urandom_range(0, 7));
      bus.write_data  = $urandom;
      bus.r_en        = 1'($urandom_range(0, 1));
      bus.r1          = 5'($urandom_range(0, 7));
      bus.r2          = 5'($urandom_range(0, 7));
      step();
      checks++;
      if ({bus.ready, bus.r1_read, bus.r2_read, bus.wr_count} !==
          {m_ready, m_r1, m_r2, 16'(m_cnt)})
        $display("FAIL random[%0d]: got rdy=%b r1=%h r2=%h cnt=%0d, want rdy=%b r1=%h r2=%h cnt=%0d",
                 i, bus.ready, bus.r1_read, bus.r2_read, bus.wr_count,
                 m_ready, m_r1, m_r2, m_cnt);
      else passed++;
    end
    rst_n = 1'b1;
    idle_all();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    test_reset();
    test_basic();
    test_zero_reg();
    test_hazard();
    test_hold_and_mid_reset();
    test_wide();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regfile_2r1w_param.md
Name: regfile_2r1w_param

Overview:
- Parametrised two-read / one-write integer register file for the RISC-V core; successor to the fixed 32x32 block.
- Width, depth and hardwired-zero index are generic.
- Contents are cleared by a post-reset sweep sequencer rather than simulation-only initialisation.
- Registered, read-enabled read ports feed the execute stage; the write port is driven by writeback.

Parameters:
XLEN, 32, data width of each register in bits
AW, 5, address width; depth NREGS = 2**AW
ZERO_IDX_EN, 1, 1 = index 0 always reads zero and ignores writes; 0 = index 0 is an ordinary register

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
ready  output  1  high when the clear sweep is complete and the file accepts accesses
rd  input  AW  write address
write_data  input  XLEN  write data
w_en  input  1  write enable
r1  input  AW  read port 1 address
r2  input  AW  read port 2 address
r_en  input  1  read enable, shared by both ports
r1_read  output  XLEN  port 1 registered read data
r2_read  output  XLEN  port 2 registered read data
wr_count  output  16  saturating count of committed writes, for debug

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset (rst_n=0 at a clk edge):
  - ready=0, r1_read=0, r2_read=0, wr_count=0.
  - FSM to CLEAR; clear pointer clr_ptr=0.
  - Register array is not modified during the reset cycle itself.
- State CLEAR: one entry zeroed per cycle at clr_ptr, then clr_ptr increments.
  - After entry NREGS-1 is written, go to RUN; ready rises on the following edge.
  - ready goes high exactly NREGS cycles after the first edge with rst_n=1.
  - w_en and r_en are ignored; outputs hold 0.
- State RUN: ready=1.
- Write:
  - If w_en=1, write_data is stored at rd at the clock edge and wr_count increments.
  - If ZERO_IDX_EN=1 and rd=0: the write is dropped and wr_count does not increment.
  - wr_count saturates at 16'hFFFF.
- Read:
  - If r_en=1, r1_read/r2_read are loaded at the edge with the contents of r1/r2. Latency is 1 cycle.
  - If r_en=0, both outputs hold their previous values.
  - If ZERO_IDX_EN=1, address 0 always reads 0.
- Same-cycle read and write to the same address: behaviour is set by REGFILE_BYPASS_EN (see Optional Feature).
- Simultaneous r1=r2: both ports return the same value.
- rst_n asserted mid-sweep or mid-operation: the FSM returns to CLEAR with clr_ptr=0 and the full sweep restarts. A write on that edge is discarded.
- Address wrap: clr_ptr is AW+1 bits wide so the terminal count is unambiguous. Addresses need no range check because all 2**AW entries exist.
- No combinational path exists from any input to any output; all outputs are registered.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN, when w_en=1 and rd equals r1 (or r2) on an edge with r_en=1, that port captures write_data (write-to-read forwarding). This lets writeback and decode share a cycle without a pipeline hazard.
  - With ZERO_IDX_EN=1, forwarding to address 0 is suppressed and 0 is returned.
- Undefined: the port captures the pre-write (old) array contents. The new value is visible from the next read onward.

Test Plan:
1. Reset and sweep: hold rst_n=0 for 3 cycles, then release with defaults -> ready=0 for 32 cycles, ready=1 on the 33rd edge. Any read then returns 0 and wr_count=0.
2. Basic write/read: write 32'hDEADBEEF to x5, then the next cycle r_en=1, r1=5, r2=7 -> one cycle later r1_read=32'hDEADBEEF, r2_read=0, wr_count=1.
3. Zero register: w_en=1, rd=0, write_data=32'h12345678, then read r1=0 -> r1_read=0 and wr_count unchanged. Repeat with ZERO_IDX_EN=0 -> r1_read=32'h12345678.
4. Same-cycle hazard: x3 holds 32'h1; write 32'hA5A5A5A5 to x3 with r_en=1, r1=3 on the same edge -> r1_read=32'hA5A5A5A5 with REGFILE_BYPASS_EN, 32'h1 without it. The next read returns 32'hA5A5A5A5 in both builds.
5. Hold and mid-sweep reset: after a read of 32'hDEADBEEF, set r_en=0 and change r1 -> r1_read stays 32'hDEADBEEF. Pulse rst_n=0 for one cycle when clr_ptr=10 -> ready stays 0 for a further full 32-cycle sweep.
6. Parameter sweep XLEN=64, AW=3: write 64'hFFFF_0000_FFFF_0001 to x7 -> it reads back intact, and ready rises 8 cycles after reset release.
